mmio_bus_bridge: RTL and testbench

//   Parametrised CPU-to-MMIO bridge for N address-decoded slave slots (DM, timers, interrupt generator, ...).

---
 rtl/mmio_bus_bridge_pkg.sv | 32 +++
 rtl/mmio_slot_decoder.sv | 40 ++++
 rtl/mmio_bus_bridge.sv | 149 ++++++++++++++
 tb/tb_mmio_bus_bridge.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bus_bridge_pkg.sv
// rtl/mmio_bus_bridge_pkg.sv - shared constants for the CPU-to-MMIO bridge
// Purpose: FSM state encodings, response error codes, the default slot map
//   (DM, TC1, TC2, interrupt generator) and a byte-enable helper.
// Ports: none (package).
package mmio_bus_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNMAP    = 2'd1;
  localparam logic [1:0] ERR_WORDONLY = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // Default 4-slot map, slot 0 in the low word:
  //   slot 0 DM     0x0000-0x0FFF
  //   slot 1 TC1    0x7F00-0x7F0F
  //   slot 2 TC2    0x7F10-0x7F1F
  //   slot 3 intgen 0x7F20-0x7F2F
  localparam logic [127:0] DEF_SLOT_BASE =
    {32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000};
  localparam logic [127:0] DEF_SLOT_MASK =
    {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_F000};
  localparam logic [3:0]   DEF_WORD_ONLY = 4'b0110;

  // A word-only slot accepts a read (0000) or a full-word write (1111).
  function automatic logic word_ok(input logic [3:0] byteen);
    return (byteen == 4'b0000) || (byteen == 4'b1111);
  endfunction

endpackage

// File: rtl/mmio_slot_decoder.sv
// rtl/mmio_slot_decoder.sv - combinational address decoder for the MMIO bridge
// Purpose: map an access address to the lowest-indexed hitting slot and flag
//   sub-word writes to word-only slots.
// Ports:
//   addr     in  32  byte address of the access
//   byteen   in  4   byte enables (0000 = read)
//   hit      out 1   some slot matched
//   slot     out SW  index of the lowest matching slot
//   wo_viol  out 1   matched slot is word-only and byteen is partial
import mmio_bus_bridge_pkg::*;

module mmio_slot_decoder #(
  parameter int                      N_SLOTS   = 4,
  parameter logic [32*N_SLOTS-1:0]   SLOT_BASE = {N_SLOTS{32'h0}},
  parameter logic [32*N_SLOTS-1:0]   SLOT_MASK = {N_SLOTS{32'h0}},
  parameter logic [N_SLOTS-1:0]      WORD_ONLY = '0,
  parameter int                      SW        = 2
) (
  input  logic [31:0]   addr,
  input  logic [3:0]    byteen,
  output logic          hit,
  output logic [SW-1:0] slot,
  output logic          wo_viol
);

  // Scan from the top down so the lowest hitting index is the last write.
  always_comb begin
    hit  = 1'b0;
    slot = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if ((addr & SLOT_MASK[32*k +: 32]) == SLOT_BASE[32*k +: 32]) begin
        hit  = 1'b1;
        slot = SW'(k);
      end
    end
  end

  assign wo_viol = hit && WORD_ONLY[slot] && !word_ok(byteen);

endmodule

// File: rtl/mmio_bus_bridge.sv
// rtl/mmio_bus_bridge.sv - CPU-to-MMIO bridge with slot decode and timeout
// Purpose: capture one CPU data access, forward it to the decoded slot with a
//   req/ready handshake, and return read data or an error code with a
//   one-cycle cpu_ack. The MEM stage stalls while cpu_busy is high.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cpu_req/addr/wdata/byteen     access pulse and payload (sampled in IDLE)
//   cpu_busy, cpu_ack             stall and response strobe
//   cpu_rdata, cpu_err            response payload, zero outside cpu_ack
//   bad_addr                      address of the most recent errored access
//   slv_req                       one-hot request, held until ready
//   slv_addr/wdata/byteen         captured access, shared by all slots
//   slv_rdata, slv_ready          per-slot read data and completion
import mmio_bus_bridge_pkg::*;

module mmio_bus_bridge #(
  parameter int                      N_SLOTS   = 4,
  parameter logic [32*N_SLOTS-1:0]   SLOT_BASE = {N_SLOTS{32'h0}},
  parameter logic [32*N_SLOTS-1:0]   SLOT_MASK = {N_SLOTS{32'h0}},
  parameter logic [N_SLOTS-1:0]      WORD_ONLY = 4'b0110,
  parameter int                      TIMEOUT   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_byteen,
  output logic                    cpu_busy,
  output logic                    cpu_ack,
  output logic [31:0]             cpu_rdata,
  output logic [1:0]              cpu_err,
  output logic [31:0]             bad_addr,
  output logic [N_SLOTS-1:0]      slv_req,
  output logic [31:0]             slv_addr,
  output logic [31:0]             slv_wdata,
  output logic [3:0]              slv_byteen,
  input  logic [32*N_SLOTS-1:0]   slv_rdata,
  input  logic [N_SLOTS-1:0]      slv_ready
);

  localparam int         SW       = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [SW-1:0] cur_slot;
  logic [7:0]    cnt;
  logic [31:0]   resp_rdata;
  logic [1:0]    resp_err;

  logic          dec_hit;
  logic [SW-1:0] dec_slot;
  logic          dec_wo_viol;

  logic          sel_ready;
  logic [31:0]   sel_rdata;

  mmio_slot_decoder #(
    .N_SLOTS   (N_SLOTS),
    .SLOT_BASE (SLOT_BASE),
    .SLOT_MASK (SLOT_MASK),
    .WORD_ONLY (WORD_ONLY),
    .SW        (SW)
  ) u_decoder (
    .addr    (cpu_addr),
    .byteen  (cpu_byteen),
    .hit     (dec_hit),
    .slot    (dec_slot),
    .wo_viol (dec_wo_viol)
  );

  // Only the active slot's ready/rdata are observed; strays are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < N_SLOTS; k++) begin
      if (cur_slot == SW'(k)) begin
        sel_ready = slv_ready[k];
        sel_rdata = slv_rdata[32*k +: 32];
      end
    end
  end

  always_comb begin
    slv_req = '0;
    if (state == ST_BUSY) slv_req[cur_slot] = 1'b1;
  end

  assign cpu_busy  = (state != ST_IDLE);
  assign cpu_ack   = (state == ST_RESP);
  assign cpu_rdata = cpu_ack ? resp_rdata : 32'h0;
  assign cpu_err   = cpu_ack ? resp_err   : ERR_NONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cur_slot   <= '0;
      cnt        <= '0;
      resp_rdata <= '0;
      resp_err   <= ERR_NONE;
      bad_addr   <= '0;
      slv_addr   <= '0;
      slv_wdata  <= '0;
      slv_byteen <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            slv_addr   <= cpu_addr;
            slv_wdata  <= cpu_wdata;
            slv_byteen <= cpu_byteen;
            cnt        <= '0;
            resp_rdata <= '0;
            if (!dec_hit) begin
              resp_err <= ERR_UNMAP;
              bad_addr <= cpu_addr;
              state    <= ST_RESP;
            end else if (dec_wo_viol) begin
              resp_err <= ERR_WORDONLY;
              bad_addr <= cpu_addr;
              state    <= ST_RESP;
            end else begin
              resp_err <= ERR_NONE;
              cur_slot <= dec_slot;
              state    <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // Ready is checked first so it beats a same-cycle timeout.
          if (sel_ready) begin
            resp_rdata <= (slv_byteen == 4'b0000) ? sel_rdata : 32'h0;
            resp_err   <= ERR_NONE;
            state      <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            resp_err <= ERR_TIMEOUT;
            bad_addr <= slv_addr;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// tb/tb_mmio_bus_bridge.sv - directed self-checking bench for mmio_bus_bridge
import mmio_bus_bridge_pkg::*;

module tb_mmio_bus_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic [31:0]  cpu_wdata;
  logic [3:0]   cpu_byteen;
  logic         cpu_busy;
  logic         cpu_ack;
  logic [31:0]  cpu_rdata;
  logic [1:0]   cpu_err;
  logic [31:0]  bad_addr;
  logic [3:0]   slv_req;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_byteen;
  logic [127:0] slv_rdata;
  logic [3:0]   slv_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mmio_bus_bridge #(
    .N_SLOTS   (4),
    .SLOT_BASE (DEF_SLOT_BASE),
    .SLOT_MASK (DEF_SLOT_MASK),
    .WORD_ONLY (DEF_WORD_ONLY),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_busy   (cpu_busy),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_err    (cpu_err),
    .bad_addr   (bad_addr),
    .slv_req    (slv_req),
    .slv_addr   (slv_addr),
    .slv_wdata  (slv_wdata),
    .slv_byteen (slv_byteen),
    .slv_rdata  (slv_rdata),
    .slv_ready  (slv_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    cpu_addr   = a;
    cpu_wdata  = d;
    cpu_byteen = be;
    cpu_req    = 1'b1;
    step();
    cpu_req    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_byteen = '0; slv_rdata = '0; slv_ready = '0;
    step(); step();

    chk("rst_busy", 32'(cpu_busy), 32'd0);
    chk("rst_ack", 32'(cpu_ack), 32'd0);
    chk("rst_slv_req", 32'(slv_req), 32'd0);
    chk("rst_bad_addr", bad_addr, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_slv_addr", slv_addr, 32'd0);
    reset = 1'b0;
    step();

    // 1: read DM, ready in first BUSY cycle -> ack at T+2
    issue(32'h0000_0000, 32'h0, 4'b0000);
    chk("t1_busy", 32'(cpu_busy), 32'd1);
    chk("t1_ack_early", 32'(cpu_ack), 32'd0);
    chk("t1_slv_req", 32'(slv_req), 32'b0001);
    slv_rdata[31:0] = 32'h1234_5678;
    slv_ready = 4'b0001;
    step();
    slv_ready = 4'b0000;
    chk("t1_ack", 32'(cpu_ack), 32'd1);
    chk("t1_rdata", cpu_rdata, 32'h1234_5678);
    chk("t1_err", 32'(cpu_err), 32'd0);
    chk("t1_slv_req_resp", 32'(slv_req), 32'd0);
    step();
    chk("t1_idle", 32'(cpu_busy), 32'd0);
    chk("t1_ack_drop", 32'(cpu_ack), 32'd0);
    chk("t1_rdata_zero", cpu_rdata, 32'd0);

    // 2: word write TC1, ready on third BUSY cycle; strays from other slots ignored
    slv_rdata[63:32] = 32'hDEAD_BEEF;
    issue(32'h0000_7F00, 32'hCAFE_F00D, 4'b1111);
    slv_ready = 4'b1101;
    chk("t2_req_c1", 32'(slv_req), 32'b0010);
    chk("t2_byteen", 32'(slv_byteen), 32'hF);
    chk("t2_wdata", slv_wdata, 32'hCAFE_F00D);
    step();
    chk("t2_req_c2", 32'(slv_req), 32'b0010);
    chk("t2_ack_c2", 32'(cpu_ack), 32'd0);
    slv_ready = 4'b0000;
    step();
    chk("t2_req_c3", 32'(slv_req), 32'b0010);
    slv_ready = 4'b0010;
    step();
    slv_ready = 4'b0000;
    chk("t2_ack", 32'(cpu_ack), 32'd1);
    chk("t2_err", 32'(cpu_err), 32'd0);
    chk("t2_rdata_write", cpu_rdata, 32'd0);
    step();

    // 3: byte write to word-only TC1 -> err 2 at T+1
    issue(32'h0000_7F04, 32'h0, 4'b0001);
    chk("t3_ack", 32'(cpu_ack), 32'd1);
    chk("t3_err", 32'(cpu_err), 32'd2);
    chk("t3_bad_addr", bad_addr, 32'h0000_7F04);
    chk("t3_no_req", 32'(slv_req), 32'd0);
    step();

    // 3b: partial write to DM (not word-only) is forwarded
    issue(32'h0000_0100, 32'h0000_00AB, 4'b0011);
    chk("t3b_req", 32'(slv_req), 32'b0001);
    chk("t3b_byteen", 32'(slv_byteen), 32'h3);
    slv_ready = 4'b0001;
    step();
    slv_ready = 4'b0000;
    chk("t3b_err", 32'(cpu_err), 32'd0);
    step();

    // 4: unmapped access -> err 1 at T+1
    issue(32'h0000_9000, 32'h0, 4'b0000);
    chk("t4_ack", 32'(cpu_ack), 32'd1);
    chk("t4_err", 32'(cpu_err), 32'd1);
    chk("t4_rdata", cpu_rdata, 32'd0);
    chk("t4_bad_addr", bad_addr, 32'h0000_9000);
    step();

    // 5: slave never ready -> ack 16 cycles after BUSY entry, err 3
    issue(32'h0000_7F20, 32'h0, 4'b0000);
    chk("t5_req", 32'(slv_req), 32'b1000);
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t5_wait_ack", 32'(cpu_ack), 32'd0);
    end
    chk("t5_still_req", 32'(slv_req), 32'b1000);
    step();
    chk("t5_ack", 32'(cpu_ack), 32'd1);
    chk("t5_err", 32'(cpu_err), 32'd3);
    chk("t5_bad_addr", bad_addr, 32'h0000_7F20);
    step();

    // 5b: ready on the last BUSY cycle beats the timeout
    slv_rdata[127:96] = 32'hA5A5_0003;
    issue(32'h0000_7F24, 32'h0, 4'b0000);
    for (int i = 0; i < 15; i++) step();
    chk("t5b_no_ack", 32'(cpu_ack), 32'd0);
    slv_ready = 4'b1000;
    step();
    slv_ready = 4'b0000;
    chk("t5b_ack", 32'(cpu_ack), 32'd1);
    chk("t5b_err", 32'(cpu_err), 32'd0);
    chk("t5b_rdata", cpu_rdata, 32'hA5A5_0003);
    chk("t5b_bad_addr_kept", bad_addr, 32'h0000_7F20);
    step();

    // 6: cpu_req during BUSY ignored; reset in BUSY aborts without ack
    issue(32'h0000_0004, 32'h0, 4'b0000);
    cpu_addr = 32'h0000_9000;
    cpu_req  = 1'b1;
    step();
    cpu_req  = 1'b0;
    chk("t6_busy", 32'(cpu_busy), 32'd1);
    chk("t6_slv_addr", slv_addr, 32'h0000_0004);
    chk("t6_bad_addr", bad_addr, 32'h0000_7F20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_busy", 32'(cpu_busy), 32'd0);
    chk("t6_rst_ack", 32'(cpu_ack), 32'd0);
    chk("t6_rst_req", 32'(slv_req), 32'd0);
    chk("t6_rst_bad", bad_addr, 32'd0);
    step();
    chk("t6_post_ack", 32'(cpu_ack), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
